fc_seq_ctrl: RTL and testbench
==============================

# fc_seq_ctrl

Sequencer for the time-multiplexed fully-connected stage. It streams one input vector of `IN` activations into a register buffer and holds that buffer stable on the shared neuron datapath. It then steps `neuron_sel` through the `NEURONS` per-neuron constant-weight adder trees and captures each ReLU result. Results stream out one per handshake, with the running argmax (class index) reported alongside the last result. It sits between the previous layer's output stream and the classifier output.

## Interface
- `WIDTH`, 8, activation width
- `IN`, 128, activations per vector
- `NEURONS`, 10, output neurons sequenced
- `LAT`, 1, datapath settle/pipeline cycles from `neuron_sel` change to valid `z_in` (≥1)
- `OW`, `2*WIDTH+$clog2(IN)`, neuron result width
- `clk` in 1: sole clock; all state updates on its rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `in_valid` in 1: input activation valid
- `in_data` in `WIDTH`: input activation, sent in index order 0..IN-1
- `in_ready` out 1: buffer accepting
- `x_bus` out `IN*WIDTH`: buffered vector to datapath; element i at bits `[i*WIDTH +: WIDTH]`
- `neuron_sel` out `$clog2(NEURONS)`: neuron datapath select
- `z_in` in `OW`: selected neuron result (ReLU applied, non-negative)
- `out_valid` out 1: result valid
- `out_data` out `OW`: result for neuron `out_idx`
- `out_idx` out `$clog2(NEURONS)`: neuron index of `out_data`
- `out_last` out 1: marks the result for neuron NEURONS-1
- `argmax` out `$clog2(NEURONS)`: index of the largest result; valid with `out_last`
- `out_ready` in 1: consumer accepts
- `busy` out 1: high whenever state ≠ IDLE

## Operation
- States: IDLE, LOAD, SETTLE, CAPTURE, OUT.
- IDLE: `in_ready`=1. The first `in_valid` handshake writes element 0, sets the write pointer to 1 and moves to LOAD.
- LOAD: `in_ready`=1. Each handshake writes `in_data` to `buf[wptr]` and increments `wptr`. The handshake at `wptr`=IN-1 moves to SETTLE with `neuron_sel`=0 and `settle_cnt`=0. Gaps in `in_valid` stall without penalty.
- SETTLE: `in_ready`=0. `settle_cnt` counts to LAT-1, then moves to CAPTURE.
- CAPTURE: one cycle. Registers `z_in` into `out_data` and `out_idx`←`neuron_sel`. Updates the argmax:
  - neuron 0 initialises the max;
  - any later neuron replaces it only on strictly greater, so ties keep the lower index.
  - Asserts `out_valid`, sets `out_last` when `neuron_sel`=NEURONS-1, then moves to OUT.
- OUT: holds outputs until `out_ready`.
  - On the handshake, if not last: `neuron_sel`+1, clear `settle_cnt`, move to SETTLE.
  - If last: clear `neuron_sel`, move to IDLE.
- `x_bus` is written only during IDLE/LOAD handshakes, so it is stable through all of SETTLE/CAPTURE/OUT.
- `argmax` is compared unsigned, at OW bits.
- Reset mid-operation discards partial vectors and pending results. No output is produced for the aborted vector.

## Timing
- Reset values:
  - state IDLE;
  - `in_ready`=1 (IDLE);
  - `out_valid`, `out_last`, `busy`=0;
  - `out_data`, `out_idx`, `argmax`, `neuron_sel`, buffer and counters = 0.
- Load takes IN accepted handshakes; the minimum is IN cycles.
- Per neuron: LAT (SETTLE) + 1 (CAPTURE) cycles to `out_valid`, plus however long `out_ready` is held low.
- Minimum vector latency from the last input handshake to the first `out_valid`: LAT+1 cycles.
- Total time with `out_ready` held high: IN + NEURONS·(LAT+2) cycles.
- `out_valid` rises registered and never drops without a handshake. `out_data`, `out_idx`, `out_last` and `argmax` stay constant while `out_valid`=1 and `out_ready`=0.
- A new vector can be accepted starting the cycle after the last output handshake; inputs are not overlapped with compute.

## Structure
- A shared package `fc_pkg` holds the state enum `fc_state_t` and the `OW` width function.
- Sub-module `argmax_track`: a registered compare/update of max value and index, with init and update strobes.
- The activation buffer is a register array; no RAM, because all elements are read in parallel.

## Test plan
- IN=128, NEURONS=10, LAT=1; send in_data=i%256; model z_in=10·sel → 10 outputs 0,10,…,90 with `out_idx` 0..9, `out_last` only on the 10th, `argmax`=9.
- Model z_in equal for neurons 3 and 7 (max 500), others 100 → `argmax`=3.
- Random `in_valid` gaps plus `out_ready` held low for 5 cycles at neuron 4 → `out_data` and `neuron_sel` stable throughout; the buffer matches the sent vector.
- LAT=3 → exactly 3 SETTLE cycles per neuron; the first `out_valid` arrives 4 cycles after the last input handshake.
- Deassert `rst_n` during OUT at neuron 6 → `out_valid`=0 and `in_ready`=1 immediately; the next vector produces a full clean sequence starting at index 0.
- Back-to-back vectors → `in_ready`=0 from the last load until the final output handshake; the second vector's results are independent of the first.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared types and width helpers for the fully-connected sequencer.
package fc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_CAPTURE,
        ST_OUT
    } fc_state_t;

    // Neuron result width: product width plus accumulation growth over n_in terms.
    function automatic int fc_ow(input int width, input int n_in);
        return 2 * width + $clog2(n_in);
    endfunction

    // Counter width that stays at least one bit for degenerate sizes.
    function automatic int fc_cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fc_seq_ctrl_argmax_track.sv
// Running maximum tracker: init loads the first value, update replaces only on strictly greater.
module argmax_track #(
    parameter int OW = 23,
    parameter int SW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          init,
    input  logic          update,
    input  logic [OW-1:0] val,
    input  logic [SW-1:0] idx,
    output logic [SW-1:0] max_idx
);

    logic [OW-1:0] max_val_reg;
    logic [SW-1:0] max_idx_reg;

    // Strict compare keeps the lower index on ties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_val_reg <= '0;
            max_idx_reg <= '0;
        end else if (init) begin
            max_val_reg <= val;
            max_idx_reg <= idx;
        end else if (update && (val > max_val_reg)) begin
            max_val_reg <= val;
            max_idx_reg <= idx;
        end
    end

    assign max_idx = max_idx_reg;

endmodule

// File: rtl/fc_seq_ctrl.sv
// Buffers one activation vector, steps the shared neuron datapath per neuron and
// streams the ReLU results out with the running argmax on the last one.
module fc_seq_ctrl
    import fc_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int IN      = 128,
    parameter int NEURONS = 10,
    parameter int LAT     = 1,
    parameter int OW      = fc_ow(WIDTH, IN)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic [IN*WIDTH-1:0]        x_bus,
    output logic [$clog2(NEURONS)-1:0] neuron_sel,
    input  logic [OW-1:0]              z_in,
    output logic                       out_valid,
    output logic [OW-1:0]              out_data,
    output logic [$clog2(NEURONS)-1:0] out_idx,
    output logic                       out_last,
    output logic [$clog2(NEURONS)-1:0] argmax,
    input  logic                       out_ready,
    output logic                       busy
);

    localparam int SW = $clog2(NEURONS);
    localparam int WP = fc_cw(IN);
    localparam int CW = fc_cw(LAT);

    fc_state_t     state_reg;
    logic [WP-1:0] wptr_reg;
    logic [CW-1:0] settle_cnt_reg;
    logic [SW-1:0] sel_reg;
    logic          in_ready_reg;
    logic          busy_reg;
    logic          out_valid_reg;
    logic          out_last_reg;
    logic [OW-1:0] out_data_reg;
    logic [SW-1:0] out_idx_reg;

    logic in_hs;
    logic cap;
    logic am_init;
    logic am_update;

    // in_ready_reg is high exactly in IDLE/LOAD, so the buffer only moves there.
    assign in_hs     = in_valid && in_ready_reg;
    assign cap       = (state_reg == ST_CAPTURE);
    assign am_init   = cap && (sel_reg == '0);
    assign am_update = cap && (sel_reg != '0);

    genvar gi;
    generate
        for (gi = 0; gi < IN; gi++) begin : g_buf
            logic [WIDTH-1:0] buf_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    buf_reg <= '0;
                end else if (in_hs && (wptr_reg == WP'(gi))) begin
                    buf_reg <= in_data;
                end
            end
            assign x_bus[gi*WIDTH +: WIDTH] = buf_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            wptr_reg       <= '0;
            settle_cnt_reg <= '0;
            sel_reg        <= '0;
            in_ready_reg   <= 1'b1;
            busy_reg       <= 1'b0;
            out_valid_reg  <= 1'b0;
            out_last_reg   <= 1'b0;
            out_data_reg   <= '0;
            out_idx_reg    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_LOAD: begin
                    if (in_hs) begin
                        busy_reg <= 1'b1;
                        if (wptr_reg == WP'(IN - 1)) begin
                            wptr_reg       <= '0;
                            sel_reg        <= '0;
                            settle_cnt_reg <= '0;
                            in_ready_reg   <= 1'b0;
                            state_reg      <= ST_SETTLE;
                        end else begin
                            wptr_reg  <= wptr_reg + WP'(1);
                            state_reg <= ST_LOAD;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt_reg == CW'(LAT - 1)) begin
                        state_reg <= ST_CAPTURE;
                    end else begin
                        settle_cnt_reg <= settle_cnt_reg + CW'(1);
                    end
                end
                ST_CAPTURE: begin
                    out_data_reg  <= z_in;
                    out_idx_reg   <= sel_reg;
                    out_valid_reg <= 1'b1;
                    out_last_reg  <= (sel_reg == SW'(NEURONS - 1));
                    state_reg     <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        out_last_reg  <= 1'b0;
                        if (out_last_reg) begin
                            sel_reg      <= '0;
                            in_ready_reg <= 1'b1;
                            busy_reg     <= 1'b0;
                            state_reg    <= ST_IDLE;
                        end else begin
                            sel_reg        <= sel_reg + SW'(1);
                            settle_cnt_reg <= '0;
                            state_reg      <= ST_SETTLE;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    argmax_track #(
        .OW(OW),
        .SW(SW)
    ) u_argmax (
        .clk    (clk),
        .rst_n  (rst_n),
        .init   (am_init),
        .update (am_update),
        .val    (z_in),
        .idx    (sel_reg),
        .max_idx(argmax)
    );

    assign in_ready   = in_ready_reg;
    assign busy       = busy_reg;
    assign neuron_sel = sel_reg;
    assign out_valid  = out_valid_reg;
    assign out_last   = out_last_reg;
    assign out_data   = out_data_reg;
    assign out_idx    = out_idx_reg;

endmodule

// File: tb/tb_fc_seq_ctrl.sv
// Scoreboard bench for fc_seq_ctrl: stimulus pushes expected results, a monitor pops on each output handshake.
module tb_fc_seq_ctrl;
    import fc_pkg::*;

    localparam int WIDTH   = 8;
    localparam int IN      = 128;
    localparam int NEURONS = 10;
    localparam int LAT     = 3;
    localparam int OW      = fc_ow(WIDTH, IN);
    localparam int SW      = $clog2(NEURONS);
    localparam int BUDGET  = 4000;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic [WIDTH-1:0]    in_data = '0;
    logic                in_ready;
    logic [IN*WIDTH-1:0] x_bus;
    logic [SW-1:0]       neuron_sel;
    logic [OW-1:0]       z_in;
    logic                out_valid;
    logic [OW-1:0]       out_data;
    logic [SW-1:0]       out_idx;
    logic                out_last;
    logic [SW-1:0]       argmax;
    logic                out_ready = 1'b0;
    logic                busy;

    always #5 clk = ~clk;

    fc_seq_ctrl #(
        .WIDTH(WIDTH), .IN(IN), .NEURONS(NEURONS), .LAT(LAT), .OW(OW)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .x_bus(x_bus), .neuron_sel(neuron_sel), .z_in(z_in),
        .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx),
        .out_last(out_last), .argmax(argmax), .out_ready(out_ready), .busy(busy)
    );

    // Datapath stand-in: result table chosen by the low bits of element 0, delayed LAT cycles after neuron_sel.
    logic [OW-1:0] ztab [4][NEURONS];
    logic [SW-1:0] sel_d [LAT];
    always @(posedge clk) begin
        sel_d[0] <= neuron_sel;
        for (int k = 1; k < LAT; k++) sel_d[k] <= sel_d[k-1];
    end
    assign z_in = ztab[x_bus[1:0]][sel_d[LAT-1]];

    typedef struct packed {
        logic [OW-1:0] d;
        logic [SW-1:0] idx;
        logic          last;
        logic [SW-1:0] am;
    } exp_t;

    exp_t                exp_q[$];
    logic [IN*WIDTH-1:0] vec_q[$];
    int                  total = 0;
    int                  bad = 0;
    longint              cyc = 0;
    bit                  span_en = 1'b0;
    int                  rdy_mode = 0;
    int                  hold_idx = -1;
    int                  hold_left = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s act=%0h req=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s (bound expired) t=%0t", nm, $time);
    endtask

    // Consumer: random or steady ready, with optional hold-low at a chosen neuron.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (out_valid && int'(out_idx) == hold_idx && hold_left > 0) begin
                out_ready = 1'b0;
                hold_left--;
            end else if (rdy_mode == 2 && out_valid && int'(out_idx) == hold_idx) begin
                out_ready = 1'b0;
            end else begin
                out_ready = (rdy_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    // Monitor: protocol, timing and scoreboard comparisons at the falling edge.
    initial begin
        bit            pv = 1'b0;
        bit            held = 1'b0;
        bit            loading = 1'b0;
        bit            computing = 1'b0;
        int            in_cnt = 0;
        longint        ref_cyc = 0;
        longint        first_cyc = 0;
        logic [OW-1:0] h_d = '0;
        logic [SW-1:0] h_i = '0, h_a = '0, h_s = '0;
        logic          h_l = 1'b0;
        exp_t          e;
        bit            is_last;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                vec_q.delete();
                pv = 1'b0; held = 1'b0; loading = 1'b0; computing = 1'b0; in_cnt = 0;
                continue;
            end
            check("in_ready", 64'(in_ready), 64'(!computing));
            check("busy", 64'(busy), 64'(loading || computing));
            if (held) begin
                check("hold_valid", 64'(out_valid), 64'(1));
                check("hold_data", 64'(out_data), 64'(h_d));
                check("hold_idx", 64'(out_idx), 64'(h_i));
                check("hold_last", 64'(out_last), 64'(h_l));
                check("hold_argmax", 64'(argmax), 64'(h_a));
                check("hold_sel", 64'(neuron_sel), 64'(h_s));
            end
            if (out_valid && !pv) check("latency", 64'(cyc - ref_cyc), 64'(LAT + 1));
            if (in_valid && in_ready) begin
                if (!loading) first_cyc = cyc + 1;
                if (in_cnt == IN - 1) begin
                    in_cnt = 0; loading = 1'b0; computing = 1'b1; ref_cyc = cyc + 1;
                end else begin
                    in_cnt++; loading = 1'b1;
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_out idx=%0d data=%0h", out_idx, out_data);
                    is_last = out_last;
                end else begin
                    e = exp_q.pop_front();
                    is_last = e.last;
                    check("out_data", 64'(out_data), 64'(e.d));
                    check("out_idx", 64'(out_idx), 64'(e.idx));
                    check("out_last", 64'(out_last), 64'(e.last));
                    if (e.last) check("argmax", 64'(argmax), 64'(e.am));
                    total++;
                    if (vec_q.size() == 0 || x_bus !== vec_q[0]) begin
                        bad++;
                        for (int k = 0; k < IN; k++) begin
                            if (vec_q.size() == 0 || x_bus[k*WIDTH +: WIDTH] !== vec_q[0][k*WIDTH +: WIDTH]) begin
                                $display("FAIL x_bus elem=%0d act=%0h req=%0h", k, x_bus[k*WIDTH +: WIDTH],
                                         (vec_q.size() == 0) ? 8'h0 : vec_q[0][k*WIDTH +: WIDTH]);
                                break;
                            end
                        end
                    end
                    if (e.last && vec_q.size() != 0) void'(vec_q.pop_front());
                end
                $display("out idx=%0d data=%0d last=%0b argmax=%0d", out_idx, out_data, out_last, argmax);
                if (is_last) begin
                    computing = 1'b0;
                    if (span_en) check("total_cycles", 64'((cyc + 1) - first_cyc + 1), 64'(IN + NEURONS * (LAT + 2)));
                end else begin
                    ref_cyc = cyc + 1;
                end
            end
            held = out_valid && !out_ready;
            h_d = out_data; h_i = out_idx; h_l = out_last; h_a = argmax; h_s = neuron_sel;
            pv = out_valid;
        end
    end

    task automatic send_vec(input int key, input bit ramp, input bit gaps);
        logic [WIDTH-1:0]    da [IN];
        logic [IN*WIDTH-1:0] v;
        exp_t                e;
        int                  best;
        int                  tmo;
        bit                  ok;
        for (int i = 0; i < IN; i++) begin
            da[i] = ramp ? WIDTH'(i % 256) : WIDTH'($urandom);
            if (i == 0 && !ramp) da[i] = {da[i][WIDTH-1:2], 2'(key)};
            v[i*WIDTH +: WIDTH] = da[i];
        end
        best = 0;
        for (int n = 1; n < NEURONS; n++) if (ztab[key][n] > ztab[key][best]) best = n;
        for (int n = 0; n < NEURONS; n++) begin
            e.d = ztab[key][n]; e.idx = SW'(n); e.last = (n == NEURONS - 1); e.am = SW'(best);
            exp_q.push_back(e);
        end
        vec_q.push_back(v);
        $display("vector key=%0d ramp=%0b gaps=%0b argmax_req=%0d", key, ramp, gaps, best);
        for (int i = 0; i < IN; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            in_data = da[i];
            in_valid = 1'b1;
            tmo = 0;
            do begin
                @(negedge clk);
                ok = in_ready;
                @(posedge clk);
                #1;
                tmo++;
            end while (!ok && tmo < BUDGET);
            if (!ok) begin
                fail_now("in_handshake");
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while (exp_q.size() != 0 && t < budget) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (exp_q.size() != 0) fail_now("drain");
    endtask

    initial begin
        int t;
        for (int n = 0; n < NEURONS; n++) begin
            ztab[0][n] = OW'(10 * n);
            ztab[1][n] = (n == 3 || n == 7) ? OW'(500) : OW'(100);
            ztab[2][n] = OW'($urandom_range(0, (1 << OW) - 1));
            ztab[3][n] = OW'($urandom_range(0, (1 << OW) - 1));
        end
        ztab[3][5] = '1;
        ztab[3][8] = '1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_last", 64'(out_last), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_out_idx", 64'(out_idx), 64'(0));
        check("rst_argmax", 64'(argmax), 64'(0));
        check("rst_sel", 64'(neuron_sel), 64'(0));
        check("rst_x_bus", 64'(x_bus == '0), 64'(1));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        span_en = 1'b1; rdy_mode = 0;
        send_vec(0, 1'b1, 1'b0);
        wait_idle(BUDGET);
        span_en = 1'b0;

        rdy_mode = 1;
        send_vec(1, 1'b0, 1'b1);
        wait_idle(BUDGET);

        rdy_mode = 0; hold_idx = 4; hold_left = 5;
        send_vec(2, 1'b0, 1'b1);
        wait_idle(BUDGET);
        hold_idx = -1;

        // Abort a vector while its neuron-6 result is pending.
        rdy_mode = 2; hold_idx = 6;
        send_vec(3, 1'b0, 1'b0);
        t = 0;
        while (!(out_valid && out_idx == SW'(6)) && t < BUDGET) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!(out_valid && out_idx == SW'(6))) fail_now("reach_neuron6");
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'(0));
        check("abort_in_ready", 64'(in_ready), 64'(1));
        check("abort_busy", 64'(busy), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold_idx = -1;

        rdy_mode = 1;
        send_vec(0, 1'b1, 1'b1);
        wait_idle(BUDGET);

        send_vec(2, 1'b0, 1'b0);
        send_vec(3, 1'b0, 1'b0);
        wait_idle(2 * BUDGET);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
